snake_body_engine: RTL and testbench

- Game-state datapath one stage downstream of the top-level snake controller.
- Owns the snake's segment list and the grid occupancy map.
- On each game tick it advances the head in the commanded direction, detects wall/self collision and food capture, and grows the body.
- Feeds o_Collision/o_Ate back to the controller; its occupancy query port serves the pixel renderer.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_occupancy_map.sv | 62 ++++++
 rtl/snake_body_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body engine: direction codes, FSM
// state encoding, default grid geometry, cell indexing and reversal detection.
package snake_pkg;

    localparam int DEF_GRID_COLS = 10;
    localparam int DEF_GRID_ROWS = 9;
    localparam int DEF_INIT_LEN  = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_RUN    = 3'd1,
        S_CALC   = 3'd2,
        S_COMMIT = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y,
                                              input int cols = DEF_GRID_COLS);
        return 8'(int'(y) * cols + int'(x));
    endfunction

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_opposite(input dir_t d0, input dir_t d1);
        return (d0[1] == d1[1]) && (d0[0] != d1[0]);
    endfunction

endpackage

// File: rtl/snake_occupancy_map.sv
// Grid occupancy bitmap: clear-all (reloading a seed pattern), set and clear
// in one cycle with set winning, plus a combinational and a registered read.
module snake_occupancy_map #(
    parameter int               CELLS     = 90,
    parameter logic [CELLS-1:0] SEED_MASK = '0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_clr_all,
    input  logic       i_set_en,
    input  logic [7:0] i_set_idx,
    input  logic       i_clr_en,
    input  logic [7:0] i_clr_idx,
    input  logic [7:0] i_rd_idx,
    output logic       o_rd_bit,
    input  logic       i_q_valid,
    input  logic [7:0] i_q_idx,
    output logic       o_q_bit
);

    localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};

    logic [CELLS-1:0] r_map;
    logic [CELLS-1:0] w_map_nxt;
    logic [CELLS-1:0] w_set_mask;
    logic [CELLS-1:0] w_clr_mask;

    // Indices past the grid shift the one-hot out entirely, so they read and write nothing.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        w_map_nxt  = r_map;
        if (i_set_en) begin
            w_set_mask = ONE << i_set_idx;
        end else begin
            w_set_mask = '0;
        end
        if (i_clr_en) begin
            w_clr_mask = ONE << i_clr_idx;
        end else begin
            w_clr_mask = '0;
        end
        if (i_clr_all) begin
            w_map_nxt = SEED_MASK;
        end else begin
            w_map_nxt = (r_map & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_rd_bit = |(r_map & (ONE << i_rd_idx));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_map   <= '0;
            o_q_bit <= 1'b0;
        end else begin
            r_map   <= w_map_nxt;
            o_q_bit <= i_q_valid & (|(r_map & (ONE << i_q_idx)));
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: segment ring buffer, tick-driven head advance with
// wall/self/food detection. Define WRAP_WALLS_EN to wrap at grid edges.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int MAX_LEN   = 90,
    parameter int INIT_LEN  = DEF_INIT_LEN
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Tick,
    input  logic [1:0] i_Dir,
    input  logic [3:0] i_Food_X,
    input  logic [3:0] i_Food_Y,
    input  logic [3:0] i_Query_X,
    input  logic [3:0] i_Query_Y,
    output logic       o_Occupied,
    output logic       o_Is_Head,
    output logic [3:0] o_Head_X,
    output logic [3:0] o_Head_Y,
    output logic [6:0] o_Length,
    output logic       o_Step_Done,
    output logic       o_Ate,
    output logic       o_Collision,
    output logic       o_Busy
);

    localparam int         CELLS   = GRID_COLS * GRID_ROWS;
    localparam logic [3:0] START_X = 4'd4;
    localparam logic [3:0] START_Y = 4'd4;

    function automatic logic [CELLS-1:0] seed_mask();
        logic [CELLS-1:0] m;
        m = '0;
        for (int k = 0; k < INIT_LEN; k++) begin
            m = m | ({{(CELLS-1){1'b0}}, 1'b1} << cell_index(4'(int'(START_X) - k), START_Y, GRID_COLS));
        end
        return m;
    endfunction

    localparam logic [CELLS-1:0] SEED = seed_mask();

    state_t     r_state, w_state_nxt;
    dir_t       r_dir;
    logic [3:0] r_seg_x [MAX_LEN];
    logic [3:0] r_seg_y [MAX_LEN];
    logic [6:0] r_head_ptr, r_length;
    logic [3:0] r_head_x, r_head_y, r_next_x, r_next_y;
    logic       r_wall, r_self, r_grow;
    logic       r_step_done, r_ate, r_collision, r_busy, r_is_head;

    logic [7:0] w_tail_sum;
    logic [6:0] w_tail_ptr, w_head_ptr_inc;
    logic [3:0] w_calc_x, w_calc_y;
    logic       w_calc_wall, w_calc_eat, w_calc_self, w_map_rd;
    logic       w_commit_ok, w_q_in;

    // Tail sits length-1 slots behind the head in the ring.
    assign w_tail_sum     = {1'b0, r_head_ptr} + 8'(MAX_LEN) - {1'b0, r_length} + 8'd1;
    assign w_tail_ptr     = (w_tail_sum >= 8'(MAX_LEN)) ? 7'(w_tail_sum - 8'(MAX_LEN)) : w_tail_sum[6:0];
    assign w_head_ptr_inc = (r_head_ptr == 7'(MAX_LEN - 1)) ? 7'd0 : r_head_ptr + 7'd1;

    always_comb begin
        w_calc_x    = r_head_x;
        w_calc_y    = r_head_y;
        w_calc_wall = 1'b0;
`ifdef WRAP_WALLS_EN
        case (r_dir)
            DIR_UP:    w_calc_y = (r_head_y == 4'd0) ? 4'(GRID_ROWS - 1) : r_head_y - 4'd1;
            DIR_DOWN:  w_calc_y = (r_head_y == 4'(GRID_ROWS - 1)) ? 4'd0 : r_head_y + 4'd1;
            DIR_LEFT:  w_calc_x = (r_head_x == 4'd0) ? 4'(GRID_COLS - 1) : r_head_x - 4'd1;
            DIR_RIGHT: w_calc_x = (r_head_x == 4'(GRID_COLS - 1)) ? 4'd0 : r_head_x + 4'd1;
            default:   w_calc_x = r_head_x;
        endcase
        w_calc_wall = 1'b0;
`else
        case (r_dir)
            DIR_UP:    w_calc_y = r_head_y - 4'd1;
            DIR_DOWN:  w_calc_y = r_head_y + 4'd1;
            DIR_LEFT:  w_calc_x = r_head_x - 4'd1;
            DIR_RIGHT: w_calc_x = r_head_x + 4'd1;
            default:   w_calc_x = r_head_x;
        endcase
        w_calc_wall = (w_calc_x >= 4'(GRID_COLS)) || (w_calc_y >= 4'(GRID_ROWS));
`endif
    end

    // Stepping onto the tail is legal unless the snake grows and the tail stays put.
    assign w_calc_eat  = (w_calc_x == i_Food_X) && (w_calc_y == i_Food_Y);
    assign w_calc_self = w_map_rd && !((w_calc_x == r_seg_x[w_tail_ptr]) &&
                                       (w_calc_y == r_seg_y[w_tail_ptr]) && !w_calc_eat);
    assign w_commit_ok = (r_state == S_COMMIT) && !r_wall && !r_self && !i_Start;
    assign w_q_in      = (i_Query_X < 4'(GRID_COLS)) && (i_Query_Y < 4'(GRID_ROWS));

    snake_occupancy_map #(
        .CELLS     (CELLS),
        .SEED_MASK (SEED)
    ) u_map (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_clr_all (i_Start),
        .i_set_en  (w_commit_ok),
        .i_set_idx (cell_index(r_next_x, r_next_y, GRID_COLS)),
        .i_clr_en  (w_commit_ok && !r_grow),
        .i_clr_idx (cell_index(r_seg_x[w_tail_ptr], r_seg_y[w_tail_ptr], GRID_COLS)),
        .i_rd_idx  (cell_index(w_calc_x, w_calc_y, GRID_COLS)),
        .o_rd_bit  (w_map_rd),
        .i_q_valid (w_q_in),
        .i_q_idx   (cell_index(i_Query_X, i_Query_Y, GRID_COLS)),
        .o_q_bit   (o_Occupied)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_Start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:    w_state_nxt = i_Tick ? S_CALC : S_RUN;
                S_CALC:   w_state_nxt = S_COMMIT;
                S_COMMIT: w_state_nxt = (r_wall || r_self) ? S_DEAD : S_RUN;
                S_WAIT:   w_state_nxt = S_WAIT;
                S_DEAD:   w_state_nxt = S_DEAD;
                default:  w_state_nxt = S_WAIT;
            endcase
        end
    end

    // Segment storage needs no reset: only slots inside the live window are ever read.
    always_ff @(posedge i_Clk) begin
        if (i_Start) begin
            for (int k = 0; k < INIT_LEN; k++) begin
                r_seg_x[7'(k)] <= 4'(int'(START_X) - (INIT_LEN - 1) + k);
                r_seg_y[7'(k)] <= START_Y;
            end
        end else if (w_commit_ok) begin
            r_seg_x[w_head_ptr_inc] <= r_next_x;
            r_seg_y[w_head_ptr_inc] <= r_next_y;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_dir       <= DIR_RIGHT;
            r_head_ptr  <= 7'd0;
            r_length    <= 7'd0;
            r_head_x    <= 4'd0;
            r_head_y    <= 4'd0;
            r_next_x    <= 4'd0;
            r_next_y    <= 4'd0;
            r_wall      <= 1'b0;
            r_self      <= 1'b0;
            r_grow      <= 1'b0;
            r_step_done <= 1'b0;
            r_ate       <= 1'b0;
            r_collision <= 1'b0;
        end else if (i_Start) begin
            r_dir       <= DIR_RIGHT;
            r_head_ptr  <= 7'(INIT_LEN - 1);
            r_length    <= 7'(INIT_LEN);
            r_head_x    <= START_X;
            r_head_y    <= START_Y;
            r_wall      <= 1'b0;
            r_self      <= 1'b0;
            r_grow      <= 1'b0;
            r_step_done <= 1'b0;
            r_ate       <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            r_ate       <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (i_Tick && !is_opposite(dir_t'(i_Dir), r_dir)) begin
                        r_dir <= dir_t'(i_Dir);
                    end
                end
                S_CALC: begin
                    r_next_x    <= w_calc_x;
                    r_next_y    <= w_calc_y;
                    r_wall      <= w_calc_wall;
                    r_self      <= w_calc_self;
                    r_grow      <= w_calc_eat && (r_length < 7'(MAX_LEN));
                    r_step_done <= 1'b1;
                    r_ate       <= w_calc_eat && (r_length < 7'(MAX_LEN)) && !w_calc_wall && !w_calc_self;
                    r_collision <= w_calc_wall || w_calc_self;
                end
                S_COMMIT: begin
                    if (!r_wall && !r_self) begin
                        r_head_ptr <= w_head_ptr_inc;
                        r_head_x   <= r_next_x;
                        r_head_y   <= r_next_y;
                        if (r_grow) begin
                            r_length <= r_length + 7'd1;
                        end
                    end
                end
                default: begin
                    r_dir <= r_dir;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_busy    <= 1'b0;
            r_is_head <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt == S_CALC) || (w_state_nxt == S_COMMIT);
            r_is_head <= w_q_in && (i_Query_X == r_head_x) && (i_Query_Y == r_head_y) &&
                         (r_length != 7'd0);
        end
    end

    assign o_Is_Head   = r_is_head;
    assign o_Head_X    = r_head_x;
    assign o_Head_Y    = r_head_y;
    assign o_Length    = r_length;
    assign o_Step_Done = r_step_done;
    assign o_Ate       = r_ate;
    assign o_Collision = r_collision;
    assign o_Busy      = r_busy;

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: a queue-based snake model predicts
// each step; a monitor compares whenever the DUT reports a finished step.
module tb_snake_body_engine;

    localparam int COLS = 10;
    localparam int ROWS = 9;
    localparam int MAXL = 90;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_Start, i_Tick;
    logic [1:0] i_Dir;
    logic [3:0] i_Food_X, i_Food_Y, i_Query_X, i_Query_Y;
    logic       o_Occupied, o_Is_Head, o_Step_Done, o_Ate, o_Collision, o_Busy;
    logic [3:0] o_Head_X, o_Head_Y;
    logic [6:0] o_Length;

    always #5 clk = ~clk;

    snake_body_engine dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Tick(i_Tick), .i_Dir(i_Dir),
        .i_Food_X(i_Food_X), .i_Food_Y(i_Food_Y), .i_Query_X(i_Query_X), .i_Query_Y(i_Query_Y),
        .o_Occupied(o_Occupied), .o_Is_Head(o_Is_Head), .o_Head_X(o_Head_X), .o_Head_Y(o_Head_Y),
        .o_Length(o_Length), .o_Step_Done(o_Step_Done), .o_Ate(o_Ate),
        .o_Collision(o_Collision), .o_Busy(o_Busy)
    );

    typedef struct {
        int ate;
        int col;
        int hx;
        int hy;
        int len;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: body as a list of cells, head first.
    int bx[$];
    int by[$];
    int mdir;
    bit mdead;
    bit mrun;
    int fx, fy;

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int in_body(int x, int y);
        for (int i = 0; i < bx.size(); i++)
            if (bx[i] == x && by[i] == y) return 1;
        return 0;
    endfunction

    function automatic int eff_dir(int d);
        return ((d ^ 1) == mdir) ? mdir : d;
    endfunction

    task automatic model_start();
        bx = '{4, 3, 2};
        by = '{4, 4, 4};
        mdir  = 3;
        mdead = 0;
        mrun  = 1;
    endtask

    task automatic model_tick(input int d, output bit acc, output exp_t e);
        int nx, ny, wall, eat, self_hit, grow;
        acc = 0;
        e = '{0, 0, 0, 0, 0};
        if (!mrun || mdead) return;
        acc  = 1;
        mdir = eff_dir(d);
        nx = bx[0];
        ny = by[0];
        case (mdir)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        wall = 0;
`ifdef WRAP_WALLS_EN
        nx = (nx + COLS) % COLS;
        ny = (ny + ROWS) % ROWS;
`else
        wall = (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) ? 1 : 0;
`endif
        eat = (nx == fx && ny == fy) ? 1 : 0;
        self_hit = 0;
        if (!wall)
            for (int i = 0; i < bx.size(); i++)
                if (bx[i] == nx && by[i] == ny && !(i == bx.size() - 1 && !eat)) self_hit = 1;
        if (wall || self_hit) begin
            mdead = 1;
            e = '{0, 1, bx[0], by[0], bx.size()};
        end else begin
            grow = (eat && bx.size() < MAXL) ? 1 : 0;
            bx.push_front(nx);
            by.push_front(ny);
            if (!grow) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            e = '{grow, 0, nx, ny, bx.size()};
        end
    endtask

    // Monitor: every reported step is matched against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_Step_Done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_step: got step_done=1, expected none (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    check("ate", int'(o_Ate), e.ate);
                    check("collision_pulse", int'(o_Collision), e.col);
                    @(negedge clk);
                    check("head_x", int'(o_Head_X), e.hx);
                    check("head_y", int'(o_Head_Y), e.hy);
                    check("length", int'(o_Length), e.len);
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        model_start();
        check("start_head_x", int'(o_Head_X), 4);
        check("start_head_y", int'(o_Head_Y), 4);
        check("start_length", int'(o_Length), 3);
        check("start_collision", int'(o_Collision), 0);
    endtask

    task automatic do_tick(input int d, input bit double_tick);
        bit   acc;
        exp_t e;
        @(negedge clk);
        i_Dir    = 2'(d);
        i_Food_X = 4'(fx);
        i_Food_Y = 4'(fy);
        i_Tick   = 1'b1;
        model_tick(d, acc, e);
        if (acc) sbq.push_back(e);
        @(negedge clk);
        if (!double_tick) i_Tick = 1'b0;
        check("busy", int'(o_Busy), int'(acc));
        @(negedge clk);
        i_Tick = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        sbq.delete();
        check("collision_level", int'(o_Collision), int'(mdead));
    endtask

    task automatic query(input int x, input int y);
        int exp_occ, exp_head;
        @(negedge clk);
        i_Query_X = 4'(x);
        i_Query_Y = 4'(y);
        @(negedge clk);
        exp_occ  = (x < COLS && y < ROWS) ? in_body(x, y) : 0;
        exp_head = (x < COLS && y < ROWS && bx.size() > 0 && bx[0] == x && by[0] == y) ? 1 : 0;
        check("occupied", int'(o_Occupied), exp_occ);
        check("is_head", int'(o_Is_Head), exp_head);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1);
    end

    initial begin
        int d, ed, nx, ny;
        rst = 1'b1;
        i_Start = 1'b0; i_Tick = 1'b0; i_Dir = 2'd3;
        i_Food_X = 4'd0; i_Food_Y = 4'd0; i_Query_X = 4'd4; i_Query_Y = 4'd4;
        fx = 0; fy = 0; mrun = 0; mdead = 0; mdir = 3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_length", int'(o_Length), 0);
        check("rst_head_x", int'(o_Head_X), 0);
        check("rst_collision", int'(o_Collision), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_step_done", int'(o_Step_Done), 0);
        query(4, 4);
        do_tick(3, 1'b0);  // ignored before start

        do_start();
        query(2, 4); query(3, 4); query(4, 4); query(1, 4); query(5, 4); query(12, 4);

        fx = 5; fy = 4;
        do_tick(3, 1'b0);
        query(2, 4); query(5, 4);

        do_start();
        fx = 0; fy = 0;
        do_tick(2, 1'b0);
        query(2, 4); query(5, 4);

        do_start();
        for (int i = 0; i < 6; i++) do_tick(3, 1'b0);
        do_tick(1, 1'b0);
        query(4, 4);

        do_start();
        fx = 5; fy = 4; do_tick(3, 1'b0);
        fx = 6; fy = 4; do_tick(3, 1'b0);
        fx = 0; fy = 0;
        do_tick(1, 1'b0); do_tick(2, 1'b0); do_tick(0, 1'b0);
        do_tick(1, 1'b0);

        do_start();
        fx = 5; fy = 4; do_tick(3, 1'b0);
        fx = 0; fy = 0;
        for (int i = 0; i < 3; i++) begin
            do_tick(1, 1'b0); do_tick(2, 1'b0); do_tick(0, 1'b0); do_tick(3, 1'b0);
        end
        query(4, 4); query(5, 5);

        do_tick(1, 1'b1);

        // Restart landing in the calculation cycle discards the step.
        @(negedge clk);
        i_Dir = 2'd1; i_Tick = 1'b1;
        @(negedge clk);
        i_Tick = 1'b0; i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        model_start();
        check("abort_head_x", int'(o_Head_X), 4);
        check("abort_length", int'(o_Length), 3);
        repeat (4) @(negedge clk);
        check("abort_head_x_late", int'(o_Head_X), 4);
        query(5, 4); query(4, 4);

        for (int it = 0; it < 300; it++) begin
            if (mdead || $urandom_range(0, 40) == 0) do_start();
            d  = int'($urandom_range(0, 3));
            ed = eff_dir(d);
            nx = bx[0] + ((ed == 3) ? 1 : (ed == 2) ? -1 : 0);
            ny = by[0] + ((ed == 1) ? 1 : (ed == 0) ? -1 : 0);
            if ($urandom_range(0, 1) == 1 && nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS) begin
                fx = nx; fy = ny;
            end else begin
                fx = int'($urandom_range(0, COLS - 1));
                fy = int'($urandom_range(0, ROWS - 1));
            end
            do_tick(d, 1'b0);
            query(int'($urandom_range(0, 11)), int'($urandom_range(0, 10)));
            query(bx[0], by[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
